tx_ep_arb: RTL

//  Arbitrates the single PCIe TRN tx interface among NREQ requesters: rx buff2tlp, tx

---
 rtl/tx_ep_arb.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/tx_ep_arb.sv
// Round-robin arbiter sharing one PCIe TRN tx port among NREQ requesters.
// Ownership changes only on TLP boundaries, with one all-idle cycle between owners.
module tx_ep_arb #(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned MAX_HOLD = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_drv_ep,
    output logic [NREQ-1:0]        req_my_trn,
    output logic [NREQ-1:0]        req_yield,
    input  logic [64*NREQ-1:0]     req_trn_td,
    input  logic [8*NREQ-1:0]      req_trn_trem_n,
    input  logic [NREQ-1:0]        req_trn_tsof_n,
    input  logic [NREQ-1:0]        req_trn_teof_n,
    input  logic [NREQ-1:0]        req_trn_tsrc_rdy_n,
    output logic [NREQ-1:0]        req_trn_tdst_rdy_n,
    output logic [63:0]            trn_td,
    output logic [7:0]             trn_trem_n,
    output logic                   trn_tsof_n,
    output logic                   trn_teof_n,
    output logic                   trn_tsrc_rdy_n,
    input  logic                   trn_tdst_rdy_n,
    output logic                   proto_err
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   gnt_idx_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_ptr_nxt;
    logic [NREQ-1:0]    my_trn_nxt;
    logic [NREQ-1:0]    yield_nxt;
    logic               in_pkt;
    logic               in_pkt_nxt;
    logic [CNT_W-1:0]   hold_cnt;
    logic [CNT_W-1:0]   hold_cnt_nxt;
    logic               proto_err_nxt;

    logic               beat;
    logic               sof_beat;
    logic               eof_beat;
    logic               own_req;
    logic               others_req;
    logic               stray_src;
    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    int unsigned        scan_idx;

    // Endpoint mux, driven straight from the registered grant vector.
    always_comb begin
        trn_td             = '0;
        trn_trem_n         = 8'hFF;
        trn_tsof_n         = 1'b1;
        trn_teof_n         = 1'b1;
        trn_tsrc_rdy_n     = 1'b1;
        req_trn_tdst_rdy_n = '1;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (req_my_trn[k]) begin
                trn_td                = req_trn_td[64*k +: 64];
                trn_trem_n            = req_trn_trem_n[8*k +: 8];
                trn_tsof_n            = req_trn_tsof_n[k];
                trn_teof_n            = req_trn_teof_n[k];
                trn_tsrc_rdy_n        = req_trn_tsrc_rdy_n[k];
                req_trn_tdst_rdy_n[k] = trn_tdst_rdy_n;
            end
        end
    end

    assign beat       = ~trn_tsrc_rdy_n & ~trn_tdst_rdy_n;
    assign sof_beat   = beat & ~trn_tsof_n;
    assign eof_beat   = beat & ~trn_teof_n;
    assign own_req    = |(req_drv_ep & req_my_trn);
    assign others_req = |(req_drv_ep & ~req_my_trn);
    assign stray_src  = |(~req_trn_tsrc_rdy_n & ~req_my_trn);

    // First requester at or after rr_ptr; scanned backwards so the nearest one wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_idx = 0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            scan_idx = 32'(rr_ptr) + (NREQ - 32'd1 - j);
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (req_drv_ep[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(scan_idx);
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        gnt_idx_nxt   = gnt_idx;
        rr_ptr_nxt    = rr_ptr;
        my_trn_nxt    = req_my_trn;
        yield_nxt     = req_yield;
        hold_cnt_nxt  = hold_cnt;
        in_pkt_nxt    = in_pkt;
        proto_err_nxt = proto_err;

        if (sof_beat && !eof_beat) begin
            in_pkt_nxt = 1'b1;
        end else if (eof_beat) begin
            in_pkt_nxt = 1'b0;
        end

        if (stray_src) begin
            proto_err_nxt = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                hold_cnt_nxt = '0;
                yield_nxt    = '0;
                if (pick_vld) begin
                    state_nxt   = ST_GRANT;
                    gnt_idx_nxt = pick_idx;
                    my_trn_nxt  = NREQ'(1) << pick_idx;
                end
            end
            ST_GRANT: begin
                if (!own_req && in_pkt) begin
                    proto_err_nxt = 1'b1;
                end
                // A dropped request is honoured only between TLPs or on the closing eof beat.
                if (!own_req && (!in_pkt || eof_beat)) begin
                    state_nxt    = ST_IDLE;
                    my_trn_nxt   = '0;
                    yield_nxt    = '0;
                    hold_cnt_nxt = '0;
                    in_pkt_nxt   = 1'b0;
                    rr_ptr_nxt   = (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
                end else if (sof_beat) begin
                    hold_cnt_nxt = '0;
                end else if (!in_pkt && others_req) begin
                    if (hold_cnt < CNT_W'(MAX_HOLD - 1)) begin
                        hold_cnt_nxt = hold_cnt + CNT_W'(1);
                    end
                    if (hold_cnt >= CNT_W'(MAX_HOLD - 2)) begin
                        yield_nxt = req_my_trn;
                    end
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                my_trn_nxt = '0;
                yield_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            gnt_idx    <= '0;
            rr_ptr     <= '0;
            req_my_trn <= '0;
            req_yield  <= '0;
            hold_cnt   <= '0;
            in_pkt     <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            gnt_idx    <= gnt_idx_nxt;
            rr_ptr     <= rr_ptr_nxt;
            req_my_trn <= my_trn_nxt;
            req_yield  <= yield_nxt;
            hold_cnt   <= hold_cnt_nxt;
            in_pkt     <= in_pkt_nxt;
            proto_err  <= proto_err_nxt;
        end
    end

endmodule
